// File: rtl/wb_trace_buffer.sv
// Writeback commit trace: queues committed register writes and streams each
// one as a 3-beat event (header with stamp/rd, pc, data) over valid/ready.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             trace_en,
    input  logic             cap_regWrite,
    input  logic [4:0]       cap_rd,
    input  logic [31:0]      cap_writeData,
    input  logic [31:0]      cap_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      drop_count,
    output logic             overflow
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STAMP_W = 16;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [4:0]         rd;
        logic [31:0]        pc;
        logic [31:0]        data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, HDR, PC, DAT} state_t;

    state_t             state_q, state_d;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_d;
    logic [STAMP_W-1:0] stamp_q;
    logic [CNT_W-1:0]   count_d;
    entry_t             new_entry, head_d;
    logic               cap, hs, pop, full, push, drop;
    logic               out_valid_d, out_last_d;
    logic [31:0]        out_data_d;

    // Capture / pop qualification and the head entry visible after this edge
    always_comb begin
        cap       = trace_en && cap_regWrite && (cap_rd != 5'd0);
        hs        = out_valid && out_ready;
        pop       = hs && (state_q == DAT);
        full      = (count == CNT_W'(DEPTH));
        push      = cap && (!full || pop);
        drop      = cap && full && !pop;
        count_d   = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        new_entry = '{stamp: stamp_q, rd: cap_rd, pc: cap_pc, data: cap_writeData};
        // An entry written this edge may become the head immediately
        head_d    = (push && (rd_ptr_d == wr_ptr)) ? new_entry : mem[rd_ptr_d];
    end

    // Serializer next state and next registered beat
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_data_d  = 32'd0;
        out_last_d  = 1'b0;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = HDR;
            HDR:     if (hs) state_d = PC;
            PC:      if (hs) state_d = DAT;
            DAT:     if (hs) state_d = (count_d != '0) ? HDR : IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            HDR: begin
                out_valid_d = 1'b1;
                out_data_d  = {head_d.stamp, 11'd0, head_d.rd};
            end
            PC: begin
                out_valid_d = 1'b1;
                out_data_d  = head_d.pc;
            end
            DAT: begin
                out_valid_d = 1'b1;
                out_data_d  = head_d.data;
                out_last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stamp_q    <= '0;
            drop_count <= 16'd0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_last   <= 1'b0;
        end else begin
            stamp_q   <= stamp_q + STAMP_W'(1);
            count     <= count_d;
            rd_ptr    <= rd_ptr_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (drop) begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (!rst && !clear && push) mem[wr_ptr] <= new_entry;
    end

endmodule
